// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined 8x8 multiplier among NREQ requesters, returns products in issue order.
// Define MULT_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module mult_arbiter #(
    parameter int NREQ       = 4,
    parameter int MULT_LAT   = 5,
    parameter int FIFO_DEPTH = 8,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              busy
);
    localparam int PW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNW = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(MULT_LAT + 1);
    localparam int OW  = $clog2(FIFO_DEPTH + MULT_LAT + 1);

    logic [MULT_LAT-1:0] tag_vld;
    logic [IDW-1:0]      tag_id [MULT_LAT];
    logic [IDW-1:0]      fifo_id [FIFO_DEPTH];
    logic [15:0]         fifo_p [FIFO_DEPTH];
    logic [PW-1:0]       wp, rp;
    logic [CNW-1:0]      count;
    logic [IFW-1:0]      inflight;
    logic                allow, any, gnt, push, pop;
    logic [IDW-1:0]      g;

    // a pop this cycle only frees credit next cycle, since count is the registered value
    assign allow = ~rst && (OW'(inflight) + OW'(count) < OW'(FIFO_DEPTH));
    assign gnt   = any & allow;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        any = 1'b0;
        g   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[k]) begin
                any = 1'b1;
                g   = IDW'(k);
            end
    end
`else
    logic [IDW-1:0] rr;
    always_comb begin
        any = 1'b0;
        g   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(rr) + k) % NREQ]) begin
                any = 1'b1;
                g   = IDW'((int'(rr) + k) % NREQ);
            end
    end

    always_ff @(posedge clk)
        if (rst) rr <= '0;
        else if (gnt) rr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
`endif

    assign req_ready = gnt ? NREQ'(1) << g : '0;
    assign mul_a     = gnt ? req_a[8*g +: 8] : '0;
    assign mul_b     = gnt ? req_b[8*g +: 8] : '0;
    assign push      = tag_vld[MULT_LAT-1];
    assign rsp_valid = ~rst && count != '0;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_id    = rsp_valid ? fifo_id[rp] : '0;
    assign rsp_data  = rsp_valid ? fifo_p[rp] : '0;
    assign busy      = ~rst && (inflight != '0 || count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            tag_vld[0] <= gnt;
            for (int i = 1; i < MULT_LAT; i++) tag_vld[i] <= tag_vld[i-1];
            if (push) wp <= (int'(wp) == FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= (int'(rp) == FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
            count    <= count + CNW'(push) - CNW'(pop);
            inflight <= inflight + IFW'(gnt) - IFW'(push);
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= g;
        for (int i = 1; i < MULT_LAT; i++) tag_id[i] <= tag_id[i-1];
        if (push && !rst) begin
            fifo_id[wp] <= tag_id[MULT_LAT-1];
            fifo_p[wp]  <= mul_p;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random stimulus against a queue-based model of the arbiter and result stream.
module tb_mult_arbiter;
    localparam int NREQ = 4, L = 5, FD = 8, IDW = $clog2(NREQ);

    logic              clk = 0, rst, rsp_ready, rsp_valid, busy;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [8*NREQ-1:0] req_a, req_b;
    logic [7:0]        mul_a, mul_b;
    logic [15:0]       mul_p, rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       mp [L];

    mult_arbiter #(.NREQ(NREQ), .MULT_LAT(L), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy));

    always #5 clk = ~clk;

    // multiplier model, deliberately not reset so stale products keep emerging
    always @(posedge clk) begin
        mp[0] <= 16'(mul_a) * 16'(mul_b);
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign mul_p = mp[L-1];

    typedef struct {int id; logic [15:0] p; int due;} exp_t;
    exp_t        q[$];
    logic [15:0] pops[$];
    logic        hv [NREQ];
    logic [7:0]  ha [NREQ], hb [NREQ];
    int checks = 0, failures = 0, cyc = 0, rr_m = 0, issued = 0, cap = 1 << 30, pct = 100;
    int last_g, first_pop, last_pop, grants;
    int gseq [8];
    bit refill = 0;
    logic obs_rv, obs_busy;
    logic [IDW-1:0] obs_id;
    logic [15:0] obs_data, pp;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_hv();
        for (int i = 0; i < NREQ; i++) hv[i] = 0;
    endtask

    task automatic cycle();
        int g, due;
        bit rv;
        logic [NREQ-1:0] er;
        logic [7:0] ea, eb;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = hv[i];
            req_a[8*i +: 8] = ha[i];
            req_b[8*i +: 8] = hb[i];
        end
        #2;
        g = -1;
        if (!rst && q.size() < FD)
            for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
                int i = k;
`else
                int i = (rr_m + k) % NREQ;
`endif
                if (g < 0 && hv[i]) g = i;
            end
        er = '0; ea = '0; eb = '0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ea = ha[g];
            eb = hb[g];
        end
        chk("req_ready", req_ready, er);
        chk("mul_a", mul_a, ea);
        chk("mul_b", mul_b, eb);
        rv = !rst && q.size() > 0 && q[0].due <= cyc;
        chk("rsp_valid", rsp_valid, rv);
        if (rv) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].p);
        end else if (rst) begin
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
        end
        chk("busy", busy, !rst && q.size() > 0);
        obs_rv = rsp_valid; obs_id = rsp_id; obs_data = rsp_data; obs_busy = busy;
        last_g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_g = i;
        if (rsp_valid && rsp_ready && !rst) begin
            if (pops.size() == 0) first_pop = cyc;
            pops.push_back(rsp_data);
            last_pop = cyc;
        end
        due = cyc + L + 1;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            rr_m = 0;
        end else begin
            if (rv && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                pp = 16'(ha[g]) * 16'(hb[g]);
                q.push_back('{id: g, p: pp, due: due});
                rr_m = (g + 1) % NREQ;
                hv[g] = 0;
                issued++;
            end
        end
        if (issued >= cap) clear_hv();
        else if (refill)
            for (int i = 0; i < NREQ; i++)
                if (!hv[i] && $urandom_range(99) < pct) begin
                    hv[i] = 1;
                    ha[i] = 8'($urandom);
                    hb[i] = 8'($urandom);
                end
    endtask

    initial begin
        rst = 1; rsp_ready = 0; req_valid = '0; req_a = '0; req_b = '0;
        clear_hv();
        for (int i = 0; i < NREQ; i++) begin ha[i] = 0; hb[i] = 0; end
        repeat (3) cycle();
        rst = 0; rsp_ready = 1;
        repeat (4) cycle();

        hv[2] = 1; ha[2] = 200; hb[2] = 150;
        cycle();
        chk("single_grant", last_g, 2);
        repeat (5) cycle();
        cycle();
        chk("single_rv", obs_rv, 1);
        chk("single_id", obs_id, 2);
        chk("single_data", obs_data, 30000);

        pops.delete();
        hv[1] = 1; ha[1] = 255; hb[1] = 255;
        cycle();
        hv[3] = 1; ha[3] = 0; hb[3] = 255;
        repeat (12) cycle();
        chk("corner_n", pops.size(), 2);
        if (pops.size() == 2) begin
            chk("corner_max", pops[0], 65025);
            chk("corner_zero", pops[1], 0);
        end

        refill = 1; pct = 100; rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 8; k++) begin cycle(); gseq[k] = last_g; end
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 8; k++) chk("fair_order", gseq[k], 0);
`else
        for (int k = 0; k < 8; k++) chk("fair_order", gseq[k], k % NREQ);
`endif

        rsp_ready = 0; rst = 1;
        cycle();
        rst = 0; grants = 0;
        repeat (16) begin cycle(); grants += (last_g >= 0) ? 1 : 0; end
        chk("bp_grants", grants, 8);
        rsp_ready = 1;
        cycle();
        chk("bp_pop", obs_rv, 1);
        chk("bp_pop_nogrant", last_g, -1);
        rsp_ready = 0;
        cycle();
        chk("bp_regrant", last_g >= 0, 1);
        grants = 0;
        repeat (3) begin cycle(); grants += (last_g >= 0) ? 1 : 0; end
        chk("bp_after", grants, 0);

        rsp_ready = 1; rst = 1;
        cycle();
        rst = 0; pops.delete(); issued = 0; cap = 100;
        for (int n = 0; n < 400 && pops.size() < 100; n++) cycle();
        chk("tput_n", pops.size(), 100);
        chk("tput_span", last_pop - first_pop, 99);
        chk("tput_issued", issued, 100);

        rsp_ready = 0; rst = 1; cap = 1 << 30;
        cycle();
        rst = 0; issued = 0; cap = 5;
        repeat (7) cycle();
        chk("mid_issued", issued, 5);
        rst = 1;
        cycle();
        rst = 0; rsp_ready = 1; refill = 0; cap = 1 << 30; pops.delete();
        clear_hv();
        cycle();
        chk("mid_rv", obs_rv, 0);
        chk("mid_busy", obs_busy, 0);
        repeat (10) cycle();
        chk("mid_stale", pops.size(), 0);
        hv[1] = 1; ha[1] = 8'($urandom); hb[1] = 8'($urandom);
        pp = 16'(ha[1]) * 16'(hb[1]);
        repeat (9) cycle();
        chk("mid_new_n", pops.size(), 1);
        if (pops.size() == 1) chk("mid_new_data", pops[0], pp);

        refill = 1; pct = 40;
        repeat (400) begin rsp_ready = 1'($urandom_range(1)); cycle(); end
        refill = 0; rsp_ready = 1;
        clear_hv();
        repeat (20) cycle();
        chk("drain_idle", obs_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
